// File: rtl/ff_reg_arbiter.sv
// Round-robin arbiter and write controller for one shared WIDTH-bit register.
// The current owner's data is captured every cycle it holds grant, up to MAX_HOLD cycles.
module ff_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic [WIDTH-1:0]           q
);

    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state;
    logic [OW-1:0]    ptr;
    logic [HW-1:0]    hold_cnt;

    logic             found;
    logic [OW-1:0]    pick;
    logic [N_REQ-1:0] pick_onehot;
    logic [WIDTH-1:0] pick_data;
    logic [WIDTH-1:0] owner_data;
    logic [OW-1:0]    next_ptr;
    logic             keep_hold;

    // Search starts at ptr and wraps, so the most recently released owner is served last.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    always_comb begin
        pick_onehot       = '0;
        pick_onehot[pick] = 1'b1;
    end

    assign pick_data  = wdata[int'(pick) * WIDTH +: WIDTH];
    assign owner_data = wdata[int'(owner) * WIDTH +: WIDTH];
    assign next_ptr   = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign keep_hold  = req[owner] && (hold_cnt < HW'(MAX_HOLD));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            ack      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            q        <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= pick_onehot;
                        ack      <= pick_onehot;
                        owner    <= pick;
                        q        <= pick_data;
                        hold_cnt <= HW'(1);
                        busy     <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (keep_hold) begin
                        q        <= owner_data;
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        // Release wins over any waiting request; q keeps its last capture.
                        grant    <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        ptr      <= next_ptr;
                        state    <= IDLE;
                    end
                end
                default: begin
                    grant    <= '0;
                    busy     <= 1'b0;
                    hold_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_reg_arbiter.sv
// Bench for ff_reg_arbiter: table vectors and hand sequences feed an expected-output queue
// that is drained and compared one cycle after each stimulus edge.
module tb_ff_reg_arbiter;

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] ack;
        logic [1:0] owner;
        logic       busy;
        logic [7:0] q;
    } out_t;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        out_t        exp;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;

    out_t expq[$];
    int   nvec;
    int   nmiss;
    vec_t tbl[18];

    ff_reg_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(15)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .wdata   (wdata),
        .grant   (grant),
        .ack     (ack),
        .owner   (owner),
        .busy    (busy),
        .q       (q)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic out_t mk(input logic [3:0] g, input logic [3:0] a,
                                input logic [1:0] o, input logic b, input logic [7:0] d);
        out_t r;
        r.grant = g;
        r.ack   = a;
        r.owner = o;
        r.busy  = b;
        r.q     = d;
        return r;
    endfunction

    task automatic checkOutput(input string name);
        out_t act;
        out_t exp;
        act = {grant, ack, owner, busy, q};
        nvec++;
        if (expq.size() == 0) begin
            nmiss++;
            $display("[TB] FAIL %s: no expected entry queued, got %h", name, act);
        end else begin
            exp = expq.pop_front();
            if (act !== exp) begin
                nmiss++;
                $display("[TB] FAIL %s: got grant=%b ack=%b owner=%0d busy=%b q=%h, expected grant=%b ack=%b owner=%0d busy=%b q=%h",
                         name, act.grant, act.ack, act.owner, act.busy, act.q,
                         exp.grant, exp.ack, exp.owner, exp.busy, exp.q);
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] w,
                                 input out_t e, input string name);
        @(negedge clock);
        req   = r;
        wdata = w;
        expq.push_back(e);
        @(posedge clock);
        #1;
        checkOutput(name);
    endtask

    initial begin
        logic [1:0] o;
        logic [7:0] d;
        logic [3:0] g;
        logic [7:0] lastq;

        nvec  = 0;
        nmiss = 0;

        // After reset ptr=0; each row's comment gives the intent of that edge.
        tbl[0]  = '{4'b0000, 32'h0000_0000, mk(4'b0000, 4'b0000, 2'd0, 1'b0, 8'h00)};
        tbl[1]  = '{4'b0010, 32'h0000_A500, mk(4'b0010, 4'b0010, 2'd1, 1'b1, 8'hA5)};
        tbl[2]  = '{4'b0010, 32'h0000_A500, mk(4'b0010, 4'b0000, 2'd1, 1'b1, 8'hA5)};
        tbl[3]  = '{4'b0000, 32'h0000_A500, mk(4'b0000, 4'b0000, 2'd1, 1'b0, 8'hA5)};
        tbl[4]  = '{4'b0000, 32'h0000_0000, mk(4'b0000, 4'b0000, 2'd1, 1'b0, 8'hA5)};
        tbl[5]  = '{4'b0100, 32'h0011_0000, mk(4'b0100, 4'b0100, 2'd2, 1'b1, 8'h11)};
        tbl[6]  = '{4'b0101, 32'h0022_00EE, mk(4'b0100, 4'b0000, 2'd2, 1'b1, 8'h22)};
        tbl[7]  = '{4'b0100, 32'h0033_0000, mk(4'b0100, 4'b0000, 2'd2, 1'b1, 8'h33)};
        tbl[8]  = '{4'b0000, 32'h0044_0000, mk(4'b0000, 4'b0000, 2'd2, 1'b0, 8'h33)};
        // ptr=3 now: requester 3 beats requester 0 through the wrap.
        tbl[9]  = '{4'b1001, 32'hC000_00D0, mk(4'b1000, 4'b1000, 2'd3, 1'b1, 8'hC0)};
        tbl[10] = '{4'b0001, 32'hC100_00D1, mk(4'b0000, 4'b0000, 2'd3, 1'b0, 8'hC0)};
        tbl[11] = '{4'b0001, 32'hC200_00D2, mk(4'b0001, 4'b0001, 2'd0, 1'b1, 8'hD2)};
        tbl[12] = '{4'b0000, 32'h0000_0000, mk(4'b0000, 4'b0000, 2'd0, 1'b0, 8'hD2)};
        tbl[13] = '{4'b0010, 32'h0000_5A00, mk(4'b0010, 4'b0010, 2'd1, 1'b1, 8'h5A)};
        // Owner 1 drops as requester 3 rises: release first, grant on the following edge.
        tbl[14] = '{4'b1000, 32'h7700_0000, mk(4'b0000, 4'b0000, 2'd1, 1'b0, 8'h5A)};
        tbl[15] = '{4'b1000, 32'h7700_0000, mk(4'b1000, 4'b1000, 2'd3, 1'b1, 8'h77)};
        tbl[16] = '{4'b0000, 32'h0000_0000, mk(4'b0000, 4'b0000, 2'd3, 1'b0, 8'h77)};
        tbl[17] = '{4'b0000, 32'h0000_0000, mk(4'b0000, 4'b0000, 2'd3, 1'b0, 8'h77)};

        reset_n = 1'b1;
        req     = '0;
        wdata   = '0;
        #2;
        reset_n = 1'b0;
        #1;
        expq.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 8'h00));
        checkOutput("reset_state");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++)
            applyStimulus(tbl[i].req, tbl[i].wdata, tbl[i].exp, $sformatf("table_%0d", i));

        // Full contention, ptr=0: owners 0,1,2,3,0, each 15 cycles then one idle edge.
        for (int r = 0; r < 5; r++) begin
            o = 2'(r % 4);
            d = 8'((int'(o) + 1) * 17);
            g = 4'(1 << o);
            for (int c = 0; c < 15; c++)
                applyStimulus(4'b1111, 32'h4433_2211,
                              mk(g, (c == 0) ? g : 4'b0000, o, 1'b1, d),
                              $sformatf("rotation_r%0d_c%0d", r, c));
            applyStimulus((r == 4) ? 4'b0000 : 4'b1111, 32'h4433_2211,
                          mk(4'b0000, 4'b0000, o, 1'b0, d),
                          $sformatf("rotation_gap_r%0d", r));
        end

        // Sole requester 0 for 40 cycles, data = cycle index: 15 on, 1 off, 15 on, 1 off, 8 on.
        lastq = 8'h11;
        for (int p = 0; p < 40; p++) begin
            if ((p % 16) == 15) begin
                applyStimulus(4'b0001, {24'h0, 8'(p)},
                              mk(4'b0000, 4'b0000, 2'd0, 1'b0, lastq),
                              $sformatf("timeout_p%0d", p));
            end else begin
                lastq = 8'(p);
                applyStimulus(4'b0001, {24'h0, 8'(p)},
                              mk(4'b0001, ((p % 16) == 0) ? 4'b0001 : 4'b0000, 2'd0, 1'b1, lastq),
                              $sformatf("timeout_p%0d", p));
            end
        end
        applyStimulus(4'b0000, 32'h0000_0028,
                      mk(4'b0000, 4'b0000, 2'd0, 1'b0, 8'd39), "timeout_release");

        // Reset in the middle of a hold clears outputs without waiting for an edge.
        applyStimulus(4'b0001, 32'h0000_4B99, mk(4'b0001, 4'b0001, 2'd0, 1'b1, 8'h99), "midreset_grant");
        for (int c = 1; c < 5; c++)
            applyStimulus(4'b0001, 32'h0000_4B99, mk(4'b0001, 4'b0000, 2'd0, 1'b1, 8'h99),
                          $sformatf("midreset_hold_%0d", c));
        #2;
        reset_n = 1'b0;
        req     = 4'b0000;
        #1;
        expq.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 8'h00));
        checkOutput("midreset_cleared");
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(4'b0010, 32'h0000_4B99, mk(4'b0010, 4'b0010, 2'd1, 1'b1, 8'h4B), "postreset_grant");
        applyStimulus(4'b0000, 32'h0000_4B99, mk(4'b0000, 4'b0000, 2'd1, 1'b0, 8'h4B), "postreset_release");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
